time_counter: RTL

- Sits directly downstream of the clock divider; consumes its CP square wave as a 1 s time base.
- Keeps time of day in packed BCD (hh:mm:ss); accepts validated time-set requests over a valid/ready handshake.
- Feeds the display/mux stage.
- Single clock domain: CP is sampled on CLK, never used as a clock.

---
 rtl/time_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/time_counter.sv
// time_counter: packed-BCD hh:mm:ss time of day advanced by rising edges of CP.
// Optional alarm logic is built only when TIME_COUNTER_ALARM_EN is defined.
module time_counter #(
    parameter int HOUR_MAX  = 23,
    parameter int ALARM_LEN = 30
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        CP,
    input  logic        run,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    output logic        set_ready,
    output logic        set_err,
    output logic [7:0]  hh,
    output logic [7:0]  mm,
    output logic [7:0]  ss,
    output logic        tick,
    output logic        day_wrap,
    input  logic        alarm_valid,
    input  logic [23:0] alarm_time,
    input  logic        alarm_ack,
    output logic        alarm_on
);

    localparam logic [7:0] HMAX_BCD =
        8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));

    typedef enum logic [1:0] {
        INIT,
        RUN,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        cp_q;
    logic        cp_edge;
    logic        set_blk;
    logic        set_acc;
    logic        set_ok;
    logic        adv;
    logic        wrap;
    logic [23:0] t_inc;

    function automatic logic bcd_ok(input logic [23:0] t);
        return (t[23:20] <= 4'd9) && (t[19:16] <= 4'd9) &&
               (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) &&
               (t[23:16] <= HMAX_BCD);
    endfunction

    function automatic logic [7:0] inc_bcd(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign cp_edge   = CP & ~cp_q;
    assign set_ready = (state != INIT) & ~set_blk;
    assign set_acc   = set_valid & set_ready;
    assign set_ok    = set_acc & bcd_ok(set_time);
    // An accepted set (valid or not) swallows a coincident second edge.
    assign adv       = (state == RUN) & run & cp_edge & ~set_acc;

    always_comb begin
        t_inc = {hh, mm, inc_bcd(ss)};
        wrap  = 1'b0;
        if (ss == 8'h59) begin
            t_inc[7:0]  = 8'h00;
            t_inc[15:8] = inc_bcd(mm);
            if (mm == 8'h59) begin
                t_inc[15:8]  = 8'h00;
                t_inc[23:16] = inc_bcd(hh);
                if (hh == HMAX_BCD) begin
                    t_inc[23:16] = 8'h00;
                    wrap         = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    state_nx = RUN;
            RUN:     if (!run) state_nx = HOLD;
            HOLD:    if (run) state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            cp_q     <= 1'b1;
            set_blk  <= 1'b0;
            set_err  <= 1'b0;
            tick     <= 1'b0;
            day_wrap <= 1'b0;
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
        end else begin
            state    <= state_nx;
            cp_q     <= CP;
            set_blk  <= set_acc;
            set_err  <= set_acc & ~set_ok;
            tick     <= adv;
            day_wrap <= adv & wrap;
            if (set_ok)
                {hh, mm, ss} <= set_time;
            else if (adv)
                {hh, mm, ss} <= t_inc;
        end
    end

`ifdef TIME_COUNTER_ALARM_EN
    logic [23:0] alarm_q;
    logic [7:0]  alarm_cnt;
    logic [23:0] t_nx;
    logic        match;

    assign t_nx  = set_ok ? set_time : t_inc;
    assign match = (set_ok | adv) & (t_nx == alarm_q);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            alarm_q   <= 24'h000000;
            alarm_cnt <= 8'd0;
            alarm_on  <= 1'b0;
        end else begin
            if (alarm_valid && bcd_ok(alarm_time))
                alarm_q <= alarm_time;
            if (alarm_ack) begin
                alarm_on  <= 1'b0;
                alarm_cnt <= 8'd0;
            end else if (match) begin
                alarm_on  <= 1'b1;
                alarm_cnt <= 8'(ALARM_LEN);
            end else if (alarm_on && adv) begin
                alarm_cnt <= alarm_cnt - 8'd1;
                if (alarm_cnt == 8'd1)
                    alarm_on <= 1'b0;
            end
        end
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_valid, alarm_time, alarm_ack, 8'(ALARM_LEN)};
    assign alarm_on     = 1'b0;
`endif

endmodule
